// File: rtl/gate_bist_checker.sv
// Built-in self-test sequencer for a 2-input combinational gate.
// Walks {a,b} through 00, 01, 10, 11, holds each vector for SETTLE cycles,
// samples the gate response for one cycle and compares it against
// TRUTH_TABLE. Reports per-vector failures, a mismatch count and a pass flag.
module gate_bist_checker #(
   parameter logic [3:0]  TRUTH_TABLE = 4'b1110,
   parameter int unsigned SETTLE      = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       dut_a,
   output logic       dut_b,
   input  logic       dut_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_vec
);

   typedef enum logic [1:0] {
      StIdle,
      StDrive,
      StSample,
      StDone
   } state_e;

   // Terminal value of the settle counter; DRIVE covers counts 0..SETTLE-1.
   localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

   state_e     state_q;
   logic [1:0] idx_q;
   logic [3:0] settle_q;

   logic       mismatch;
   logic [2:0] err_next;
   logic [1:0] idx_inc;

   // Response check for the vector currently applied, and the next index.
   always_comb begin
      mismatch = (dut_y != TRUTH_TABLE[idx_q]);
      err_next = err_count + {2'b00, mismatch};
      idx_inc  = idx_q + 2'd1;
   end

   // Sequencer FSM with all outputs registered; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         idx_q     <= 2'd0;
         settle_q  <= 4'd0;
         dut_a     <= 1'b0;
         dut_b     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= 3'd0;
         fail_vec  <= 4'd0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q   <= StDrive;
                  idx_q     <= 2'd0;
                  settle_q  <= 4'd0;
                  dut_a     <= 1'b0;
                  dut_b     <= 1'b0;
                  busy      <= 1'b1;
                  pass      <= 1'b0;
                  err_count <= 3'd0;
                  fail_vec  <= 4'd0;
               end
            end
            StDrive: begin
               if (settle_q == SettleLast) begin
                  state_q <= StSample;
               end else begin
                  settle_q <= settle_q + 4'd1;
               end
            end
            StSample: begin
               // At most one increment per vector, so the count tops out at 4.
               if (mismatch) begin
                  fail_vec[idx_q] <= 1'b1;
                  err_count       <= err_next;
               end
               if (idx_q == 2'd3) begin
                  state_q <= StDone;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  pass    <= (err_next == 3'd0);
                  dut_a   <= 1'b0;
                  dut_b   <= 1'b0;
               end else begin
                  state_q  <= StDrive;
                  idx_q    <= idx_inc;
                  settle_q <= 4'd0;
                  dut_a    <= idx_inc[1];
                  dut_b    <= idx_inc[0];
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench for gate_bist_checker: one configurable main instance plus
// instances with an AND table and with SETTLE=1 / SETTLE=15.
module tb_gate_bist_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start;
   logic       dut_a, dut_b, dut_y, busy, done, pass;
   logic [2:0] err_count;
   logic [3:0] fail_vec;
   int         mode;  // 0: ideal OR, 1: stuck-at-0, 2: AND

   assign dut_y = (mode == 0) ? (dut_a | dut_b) :
                  (mode == 1) ? 1'b0 : (dut_a & dut_b);

   logic [11:0] main_obs;
   assign main_obs = {dut_a, dut_b, busy, done, pass, err_count, fail_vec};

   gate_bist_checker u_dut (
      .clk(clk), .rst(rst), .start(start), .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
   );

   logic       start_and, a_and, b_and, busy_and, done_and, pass_and;
   logic [2:0] err_and;
   logic [3:0] fail_and;
   gate_bist_checker #(.TRUTH_TABLE(4'b1000), .SETTLE(2)) u_and (
      .clk(clk), .rst(rst), .start(start_and), .dut_a(a_and), .dut_b(b_and),
      .dut_y(a_and & b_and), .busy(busy_and), .done(done_and), .pass(pass_and),
      .err_count(err_and), .fail_vec(fail_and)
   );

   logic       start_s1, a_s1, b_s1, busy_s1, done_s1, pass_s1;
   logic [2:0] err_s1;
   logic [3:0] fail_s1;
   gate_bist_checker #(.SETTLE(1)) u_s1 (
      .clk(clk), .rst(rst), .start(start_s1), .dut_a(a_s1), .dut_b(b_s1),
      .dut_y(a_s1 | b_s1), .busy(busy_s1), .done(done_s1), .pass(pass_s1),
      .err_count(err_s1), .fail_vec(fail_s1)
   );

   logic       start_s15, a_s15, b_s15, busy_s15, done_s15, pass_s15;
   logic [2:0] err_s15;
   logic [3:0] fail_s15;
   gate_bist_checker #(.SETTLE(15)) u_s15 (
      .clk(clk), .rst(rst), .start(start_s15), .dut_a(a_s15), .dut_b(b_s15),
      .dut_y(a_s15 | b_s15), .busy(busy_s15), .done(done_s15), .pass(pass_s15),
      .err_count(err_s15), .fail_vec(fail_s15)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse start from IDLE and return the cycle (1 = first after accept) of done.
   task automatic run_main(output int lat);
      lat   = -1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         if (done) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
   endtask

   int lat, done_first, done_second, done_cnt;
   int lat_and, lat_s1, lat_s15;
   logic p_and, p_s1, p_s15;
   logic [2:0] e_and, e_s1, e_s15;

   initial begin
      rst = 1'b1; start = 1'b0; mode = 0;
      start_and = 1'b0; start_s1 = 1'b0; start_s15 = 1'b0;
      repeat (2) @(negedge clk);
      check_value("reset_state", main_obs, 12'h000);
      check_value("reset_aux", {busy_and, done_and, busy_s1, done_s1, busy_s15, done_s15}, 0);

      // Reset outranks a simultaneous start.
      start = 1'b1;
      @(negedge clk);
      check_value("rst_over_start", busy, 1'b0);

      // Release reset with start still high: accepted on the first edge.
      rst = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         logic [1:0]  v;
         logic [11:0] exp;
         v = 2'((c - 1) / 3);
         if (c <= 12) exp = {v, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
         else         exp = {2'b00, 1'b0, 1'b1, 1'b1, 3'd0, 4'd0};
         check_value($sformatf("or_trace_c%0d", c), main_obs, exp);
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check_value("or_hold", {pass, err_count, fail_vec, busy, done}, {1'b1, 3'd0, 4'd0, 2'b00});

      // Gate output stuck at 0 against the OR table.
      mode = 1;
      run_main(lat);
      check_value("stuck0_latency", lat, 13);
      check_value("stuck0_result", {pass, err_count, fail_vec}, {1'b0, 3'd3, 4'b1110});
      repeat (3) @(negedge clk);
      check_value("stuck0_hold", {pass, err_count, fail_vec}, {1'b0, 3'd3, 4'b1110});

      // AND gate against the default OR table.
      mode = 2;
      run_main(lat);
      check_value("and_vs_or", {pass, err_count, fail_vec}, {1'b0, 3'd2, 4'b0110});
      repeat (2) @(negedge clk);

      // Start held high continuously.
      mode = 0;
      done_first = -1; done_second = -1; done_cnt = 0;
      start = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 30; c++) begin
         if (done) begin
            done_cnt++;
            if (done_first < 0) done_first = c;
            else if (done_second < 0) done_second = c;
         end
         if (c == 7)  check_value("held_no_restart_c7", {dut_a, dut_b}, 2'b10);
         if (c == 20) check_value("held_run2_c20", {dut_a, dut_b}, 2'b01);
         @(negedge clk);
      end
      start = 1'b0;
      check_value("held_done_first", done_first, 13);
      check_value("held_done_second", done_second, 27);
      check_value("held_done_count", done_cnt, 2);
      repeat (15) @(negedge clk);

      // Abort during vector 2 SAMPLE with a stuck-at-0 fault.
      mode = 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check_value("pre_abort", {dut_a, dut_b, busy, err_count, fail_vec}, {3'b101, 3'd1, 4'b0010});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_value("abort_clear", main_obs, 12'h000);
      done_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      check_value("abort_no_done", done_cnt, 0);
      run_main(lat);
      check_value("rerun_latency", lat, 13);
      check_value("rerun_result", {pass, err_count, fail_vec}, {1'b0, 3'd3, 4'b1110});
      repeat (2) @(negedge clk);

      // Parameter variants, run side by side.
      lat_and = -1; lat_s1 = -1; lat_s15 = -1;
      p_and = 1'b0; p_s1 = 1'b0; p_s15 = 1'b0;
      e_and = 3'd7; e_s1 = 3'd7; e_s15 = 3'd7;
      start_and = 1'b1; start_s1 = 1'b1; start_s15 = 1'b1;
      @(negedge clk);
      start_and = 1'b0; start_s1 = 1'b0; start_s15 = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         if (done_and && lat_and < 0) begin lat_and = c; p_and = pass_and; e_and = err_and; end
         if (done_s1 && lat_s1 < 0)   begin lat_s1 = c;  p_s1 = pass_s1;   e_s1 = err_s1;   end
         if (done_s15 && lat_s15 < 0) begin lat_s15 = c; p_s15 = pass_s15; e_s15 = err_s15; end
         @(negedge clk);
      end
      check_value("and_table_latency", lat_and, 13);
      check_value("and_table_result", {p_and, e_and}, {1'b1, 3'd0});
      check_value("settle1_latency", lat_s1, 9);
      check_value("settle1_result", {p_s1, e_s1}, {1'b1, 3'd0});
      check_value("settle15_latency", lat_s15, 65);
      check_value("settle15_result", {p_s15, e_s15, fail_s15}, {1'b1, 3'd0, 4'd0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
